encoder8_3: RTL and testbench



---
 rtl/encoder8_3.sv | 89 ++++++++
 tb/tb_encoder8_3.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/encoder8_3.sv
// Sequential 8-to-3 request encoder: accumulates multi-hot request strobes and
// emits one binary index per pending bit, in fixed priority order, over valid/ready.
module encoder8_3 #(
  parameter bit PRIO_LSB = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       req_valid,
  output logic [2:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [7:0] pending,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state, state_next;
  logic [W-1:0] sel, code_next;
  logic [N-1:0] pending_next, clear_mask;
  logic         overflow_next;
  int unsigned  idx;

  // Priority pick over registered pending; the last hit in scan order wins.
  always_comb begin
    sel = '0;
    idx = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PRIO_LSB ? (N - 1 - i) : i;
      if (pending[W'(idx)]) sel = W'(idx);
    end
  end

  // Output-slot FSM, pending merge and overflow detection.
  always_comb begin
    state_next = state;
    code_next  = code;
    clear_mask = '0;
    case (state)
      EMPTY: begin
        if (|pending) begin
          code_next  = sel;
          clear_mask = N'(1) << sel;
          state_next = FULL;
        end
      end
      FULL: begin
        if (code_ready) begin
          if (|pending) begin
            code_next  = sel;
            clear_mask = N'(1) << sel;
          end else begin
            state_next = EMPTY;
          end
        end
      end
      default: state_next = EMPTY;
    endcase
    // A new request for the bit being loaded re-pends it rather than overflowing.
    pending_next  = (pending & ~clear_mask) | (req_valid ? req : '0);
    overflow_next = req_valid & (|(req & pending & ~clear_mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      code     <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      code     <= code_next;
      pending  <= pending_next;
      overflow <= overflow_next;
    end
  end

  assign code_valid = (state == FULL);
  assign busy       = (|pending) | code_valid;

endmodule

// File: tb/tb_encoder8_3.sv
// Directed bench for encoder8_3; runs an LSB-first and an MSB-first instance
// side by side on shared stimulus.
module tb_encoder8_3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       req_valid;
  logic       code_ready;

  logic [2:0] code_l, code_m;
  logic       cv_l, cv_m, ovf_l, ovf_m, busy_l, busy_m;
  logic [7:0] pend_l, pend_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  encoder8_3 #(.PRIO_LSB(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .req(req), .req_valid(req_valid),
    .code(code_l), .code_valid(cv_l), .code_ready(code_ready),
    .pending(pend_l), .overflow(ovf_l), .busy(busy_l)
  );

  encoder8_3 #(.PRIO_LSB(1'b0)) u_msb (
    .clk(clk), .rst(rst), .req(req), .req_valid(req_valid),
    .code(code_m), .code_valid(cv_m), .code_ready(code_ready),
    .pending(pend_m), .overflow(ovf_m), .busy(busy_m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_valid = 1'b0; code_ready = 1'b1;
    tick(); tick();
    checks++; if (pend_l !== 8'h00) begin errors++; $display("FAIL reset_pending got=%h exp=00", pend_l); end
    checks++; if (code_l !== 3'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", code_l); end
    checks++; if (cv_l !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", cv_l); end
    checks++; if (ovf_l !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", ovf_l); end
    checks++; if (busy_l !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b/%b exp=0/0", busy_l, busy_m); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    logic [2:0] exp_l [3];
    logic [2:0] exp_m [3];
    exp_l[0] = 3'd2; exp_l[1] = 3'd5; exp_l[2] = 3'd7;
    exp_m[0] = 3'd7; exp_m[1] = 3'd5; exp_m[2] = 3'd2;
    code_ready = 1'b1;
    req = 8'hA4; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req = '0;
    checks++; if (cv_l !== 1'b0 || pend_l !== 8'hA4) begin errors++; $display("FAIL prio_latency got valid=%b pend=%h exp valid=0 pend=a4", cv_l, pend_l); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cv_l !== 1'b1 || code_l !== exp_l[i]) begin errors++; $display("FAIL prio_lsb[%0d] got valid=%b code=%0d exp valid=1 code=%0d", i, cv_l, code_l, exp_l[i]); end
      checks++; if (cv_m !== 1'b1 || code_m !== exp_m[i]) begin errors++; $display("FAIL prio_msb[%0d] got valid=%b code=%0d exp valid=1 code=%0d", i, cv_m, code_m, exp_m[i]); end
      checks++; if (ovf_l !== 1'b0 || ovf_m !== 1'b0) begin errors++; $display("FAIL prio_overflow[%0d] got=%b/%b exp=0/0", i, ovf_l, ovf_m); end
    end
    tick();
    checks++; if (cv_l !== 1'b0 || busy_l !== 1'b0) begin errors++; $display("FAIL prio_drain_lsb got valid=%b busy=%b exp 0/0", cv_l, busy_l); end
    checks++; if (cv_m !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL prio_drain_msb got valid=%b busy=%b exp 0/0", cv_m, busy_m); end
  endtask

  task automatic test_backpressure();
    code_ready = 1'b0;
    req = 8'h81; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (cv_l !== 1'b1 || code_l !== 3'd0 || pend_l !== 8'h80) begin errors++; $display("FAIL hold_lsb[%0d] got valid=%b code=%0d pend=%h exp 1/0/80", i, cv_l, code_l, pend_l); end
      checks++; if (cv_m !== 1'b1 || code_m !== 3'd7 || pend_m !== 8'h01) begin errors++; $display("FAIL hold_msb[%0d] got valid=%b code=%0d pend=%h exp 1/7/01", i, cv_m, code_m, pend_m); end
    end
    code_ready = 1'b1;
    tick();
    checks++; if (cv_l !== 1'b1 || code_l !== 3'd7 || pend_l !== 8'h00) begin errors++; $display("FAIL release_lsb got valid=%b code=%0d pend=%h exp 1/7/00", cv_l, code_l, pend_l); end
    tick();
    checks++; if (cv_l !== 1'b0 || busy_l !== 1'b0) begin errors++; $display("FAIL release_empty got valid=%b busy=%b exp 0/0", cv_l, busy_l); end
  endtask

  task automatic test_overflow();
    code_ready = 1'b0;
    req = 8'h01; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    checks++; if (cv_l !== 1'b1 || code_l !== 3'd0) begin errors++; $display("FAIL ovf_setup got valid=%b code=%0d exp 1/0", cv_l, code_l); end
    req = 8'h10; req_valid = 1'b1;
    tick();
    checks++; if (ovf_l !== 1'b0 || pend_l !== 8'h10) begin errors++; $display("FAIL ovf_first got ovf=%b pend=%h exp 0/10", ovf_l, pend_l); end
    tick();
    req_valid = 1'b0; req = '0;
    checks++; if (ovf_l !== 1'b1 || ovf_m !== 1'b1 || pend_l !== 8'h10) begin errors++; $display("FAIL ovf_pulse got ovf=%b/%b pend=%h exp 1/1/10", ovf_l, ovf_m, pend_l); end
    tick();
    checks++; if (ovf_l !== 1'b0 || cv_l !== 1'b1 || code_l !== 3'd0) begin errors++; $display("FAIL ovf_clear got ovf=%b valid=%b code=%0d exp 0/1/0", ovf_l, cv_l, code_l); end
    code_ready = 1'b1;
    tick();
    checks++; if (cv_l !== 1'b1 || code_l !== 3'd4 || pend_l !== 8'h00) begin errors++; $display("FAIL ovf_code4 got valid=%b code=%0d pend=%h exp 1/4/00", cv_l, code_l, pend_l); end
    tick();
    checks++; if (cv_l !== 1'b0) begin errors++; $display("FAIL ovf_single got valid=%b exp 0", cv_l); end
  endtask

  task automatic test_set_wins();
    code_ready = 1'b1;
    req = 8'h02; req_valid = 1'b1;
    tick();
    tick();
    req_valid = 1'b0; req = '0;
    checks++; if (cv_l !== 1'b1 || code_l !== 3'd1 || pend_l !== 8'h02 || ovf_l !== 1'b0) begin errors++; $display("FAIL setwin_load got valid=%b code=%0d pend=%h ovf=%b exp 1/1/02/0", cv_l, code_l, pend_l, ovf_l); end
    tick();
    checks++; if (cv_l !== 1'b1 || code_l !== 3'd1 || pend_l !== 8'h00) begin errors++; $display("FAIL setwin_second got valid=%b code=%0d pend=%h exp 1/1/00", cv_l, code_l, pend_l); end
    tick();
    checks++; if (cv_l !== 1'b0) begin errors++; $display("FAIL setwin_empty got valid=%b exp 0", cv_l); end
  endtask

  task automatic test_reset_mid();
    code_ready = 1'b1;
    req = 8'hFF; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req = '0;
    tick();
    checks++; if (code_l !== 3'd0 || code_m !== 3'd7) begin errors++; $display("FAIL mid_first got %0d/%0d exp 0/7", code_l, code_m); end
    tick();
    checks++; if (code_l !== 3'd1 || code_m !== 3'd6) begin errors++; $display("FAIL mid_second got %0d/%0d exp 1/6", code_l, code_m); end
    rst = 1'b1;
    tick();
    checks++; if (pend_l !== 8'h00 || cv_l !== 1'b0 || code_l !== 3'd0 || busy_l !== 1'b0) begin errors++; $display("FAIL mid_reset_lsb got pend=%h valid=%b code=%0d busy=%b exp 00/0/0/0", pend_l, cv_l, code_l, busy_l); end
    checks++; if (pend_m !== 8'h00 || cv_m !== 1'b0 || code_m !== 3'd0 || busy_m !== 1'b0) begin errors++; $display("FAIL mid_reset_msb got pend=%h valid=%b code=%0d busy=%b exp 00/0/0/0", pend_m, cv_m, code_m, busy_m); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cv_l !== 1'b0 || cv_m !== 1'b0) begin errors++; $display("FAIL mid_after[%0d] got valid=%b/%b exp 0/0", i, cv_l, cv_m); end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_backpressure();
    test_overflow();
    test_set_wins();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
